// File: rtl/i2c_target_regs.sv
// I2C target with a small auto-incrementing register bank.
// Bus inputs are synchronized and glitch-filtered; every protocol decision
// is taken on edges of the filtered scl/sda levels.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h78,
    parameter int unsigned NREGS       = 4,
    parameter int unsigned FILTER      = 3
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic [8*NREGS-1:0]       regs_o,
    output logic                     wr_stb,
    output logic [$clog2(NREGS)-1:0] wr_idx,
    output logic                     busy
);
    localparam int unsigned PW = $clog2(NREGS);
    localparam int unsigned CW = $clog2(FILTER + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR_BYTE, ACK_WR, RD_BYTE, ACK_RD, IGNORE
    } state_t;

    // Index 0 carries scl, index 1 carries sda.
    logic [1:0]    r_s1, r_s2, r_f, r_fd;
    logic [CW-1:0] r_cnt [2];

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic [3:0]          r_bcnt, w_bcnt_nxt;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic                r_oe, w_oe_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_rw, w_rw_nxt;
    logic                w_we;
    logic [8*NREGS-1:0]  r_regs;
    logic                r_wr_stb;
    logic [PW-1:0]       r_wr_idx;

    logic       w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte, w_rdbyte;

    assign w_scl_f    = r_f[0];
    assign w_sda_f    = r_f[1];
    assign w_scl_rise = r_f[0] & ~r_fd[0];
    assign w_scl_fall = ~r_f[0] & r_fd[0];
    // START/STOP only count while scl has been high for two samples,
    // so they can never alias a data edge.
    assign w_start    = r_f[0] & r_fd[0] & r_fd[1] & ~r_f[1];
    assign w_stop     = r_f[0] & r_fd[0] & ~r_fd[1] & r_f[1];
    assign w_byte     = {r_shift[6:0], w_sda_f};
    assign w_rdbyte   = r_regs[{r_ptr, 3'b000} +: 8];

    // Synchronize scl/sda and accept a new level only after FILTER equal samples.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_f      <= '1;
            r_fd     <= '1;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_s1 <= {sda_i, scl_i};
            r_s2 <= r_s1;
            r_fd <= r_f;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_s2[i] == r_f[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILTER - 1)) begin
                    r_f[i]   <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Protocol next-state: ACK states use r_bcnt as a phase flag
    // (0 = waiting for the fall that starts the ACK slot, 1 = inside it).
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bcnt_nxt  = r_bcnt;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_oe;
        w_busy_nxt  = r_busy;
        w_rw_nxt    = r_rw;
        w_we        = 1'b0;
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ADDR;
            w_bcnt_nxt  = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, IGNORE: ;
                ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                    if (r_bcnt == 4'd7) begin
                        w_bcnt_nxt = '0;
                        if (w_byte[7:1] == TARGET_ADDR) begin
                            w_state_nxt = ACK_ADDR;
                            w_busy_nxt  = 1'b1;
                            w_rw_nxt    = w_byte[0];
                        end else begin
                            w_state_nxt = IGNORE;
                        end
                    end
                end
                ACK_ADDR, ACK_PTR, ACK_WR: if (w_scl_fall) begin
                    if (r_bcnt == 4'd0) begin
                        w_oe_nxt   = 1'b1;
                        w_bcnt_nxt = 4'd1;
                    end else if (r_state == ACK_ADDR && r_rw) begin
                        w_state_nxt = RD_BYTE;
                        w_shift_nxt = w_rdbyte;
                        w_oe_nxt    = ~w_rdbyte[7];
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = (r_state == ACK_ADDR) ? PTR : WR_BYTE;
                        w_oe_nxt    = 1'b0;
                        w_bcnt_nxt  = '0;
                    end
                end
                PTR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                    if (r_bcnt == 4'd7) begin
                        w_ptr_nxt   = w_byte[PW-1:0];
                        w_state_nxt = ACK_PTR;
                        w_bcnt_nxt  = '0;
                    end
                end
                WR_BYTE: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                    if (r_bcnt == 4'd7) begin
                        w_we        = 1'b1;
                        w_ptr_nxt   = r_ptr + 1'b1;
                        w_state_nxt = ACK_WR;
                        w_bcnt_nxt  = '0;
                    end
                end
                RD_BYTE: begin
                    if (w_scl_rise) begin
                        w_bcnt_nxt  = r_bcnt + 4'd1;
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                    end else if (w_scl_fall) begin
                        if (r_bcnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_ptr_nxt   = r_ptr + 1'b1;
                            w_state_nxt = ACK_RD;
                            w_bcnt_nxt  = '0;
                        end else begin
                            w_oe_nxt = ~r_shift[7];
                        end
                    end
                end
                ACK_RD: begin
                    if (w_scl_rise) begin
                        if (w_sda_f) w_state_nxt = IGNORE;
                        else         w_bcnt_nxt  = 4'd1;
                    end else if (w_scl_fall && r_bcnt == 4'd1) begin
                        w_state_nxt = RD_BYTE;
                        w_shift_nxt = w_rdbyte;
                        w_oe_nxt    = ~w_rdbyte[7];
                        w_bcnt_nxt  = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Protocol state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_ptr   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_oe    <= w_oe_nxt;
            r_busy  <= w_busy_nxt;
            r_rw    <= w_rw_nxt;
        end
    end

    // Register bank update and write strobe.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_regs   <= '0;
            r_wr_stb <= 1'b0;
            r_wr_idx <= '0;
        end else begin
            r_wr_stb <= w_we;
            if (w_we) begin
                r_regs[{r_ptr, 3'b000} +: 8] <= w_byte;
                r_wr_idx                     <= r_ptr;
            end
        end
    end

    assign sda_oe = r_oe;
    assign busy   = r_busy;
    assign regs_o = r_regs;
    assign wr_stb = r_wr_stb;
    assign wr_idx = r_wr_idx;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C master drives the target on an
// open-drain bus and checks ACKs, read data and the register bank.
module tb_i2c_target_regs;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic        sda_oe, wr_stb, busy;
    logic [31:0] regs_o;
    logic [1:0]  wr_idx;
    logic        sda_bus;

    int vectors = 0;
    int miscompares = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int idx_log [$];

    assign sda_bus = ~(m_sda_low | sda_oe);

    i2c_target_regs #(.TARGET_ADDR(7'h78), .NREGS(4), .FILTER(3)) dut (
        .aclk   (aclk),
        .areset (areset),
        .scl_i  (m_scl),
        .sda_i  (sda_bus),
        .sda_oe (sda_oe),
        .regs_o (regs_o),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx),
        .busy   (busy)
    );

    always #5 aclk = ~aclk;

    // Record write strobes and activity of sda_oe / busy.
    always @(negedge aclk) begin
        if (wr_stb) idx_log.push_back(int'(wr_idx));
        if (sda_oe) oe_cnt++;
        if (busy)   busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        tick(4);  m_sda_low = ~b;
        tick(12); m_scl = 1'b1;
        tick(8);
        if (glitch) begin
            m_sda_low = 1'b1; tick(1); m_sda_low = 1'b0; tick(7);
        end else begin
            tick(8);
        end
        m_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(4);  m_sda_low = 1'b0;
        tick(12); m_scl = 1'b1;
        tick(8);  b = sda_bus;
        tick(8);  m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch7, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], (i == 7) ? glitch7 : 1'b0);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(nack, 1'b0);
    endtask

    task automatic start_c();
        m_sda_low = 1'b1; tick(16); m_scl = 1'b0;
    endtask

    task automatic rstart_c();
        tick(4);  m_sda_low = 1'b0;
        tick(12); m_scl = 1'b1;
        tick(16); m_sda_low = 1'b1;
        tick(16); m_scl = 1'b0;
    endtask

    task automatic stop_c();
        tick(4);  m_sda_low = 1'b1;
        tick(12); m_scl = 1'b1;
        tick(16); m_sda_low = 1'b0;
        tick(16);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1;
        int         base, oe0, busy0;

        // Reset state
        tick(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'h0);
        chk("rst_regs",   regs_o,       32'h0);
        chk("rst_wr_stb", 32'(wr_stb), 32'h0);
        chk("rst_wr_idx", 32'(wr_idx), 32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        areset = 1'b0;
        tick(20);

        // Write reg1 = AA
        base = idx_log.size();
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        write_byte(8'h01, 1'b0, a1);
        write_byte(8'hAA, 1'b0, a2);
        chk("wr_ack_addr", 32'(a0), 32'h0);
        chk("wr_ack_ptr",  32'(a1), 32'h0);
        chk("wr_ack_data", 32'(a2), 32'h0);
        chk("wr_busy_mid", 32'(busy), 32'h1);
        stop_c();
        chk("wr_regs",    regs_o, 32'h0000AA00);
        chk("wr_stb_cnt", 32'(idx_log.size() - base), 32'd1);
        chk("wr_idx",     32'(idx_log[base]), 32'd1);
        chk("wr_busy_end", 32'(busy), 32'h0);

        // Wrong address: ignored entirely
        base = idx_log.size(); oe0 = oe_cnt; busy0 = busy_cnt;
        start_c();
        write_byte(8'hE0, 1'b0, a0);
        write_byte(8'h01, 1'b0, a1);
        write_byte(8'h55, 1'b0, a2);
        stop_c();
        chk("na_ack_addr", 32'(a0), 32'h1);
        chk("na_ack_ptr",  32'(a1), 32'h1);
        chk("na_ack_data", 32'(a2), 32'h1);
        chk("na_regs",     regs_o, 32'h0000AA00);
        chk("na_oe_seen",  32'(oe_cnt - oe0), 32'd0);
        chk("na_busy_seen", 32'(busy_cnt - busy0), 32'd0);
        chk("na_stb_cnt",  32'(idx_log.size() - base), 32'd0);

        // Auto-increment with wrap: reg3 = 11, reg0 = 22
        base = idx_log.size();
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        write_byte(8'h03, 1'b0, a1);
        write_byte(8'h11, 1'b0, a2);
        write_byte(8'h22, 1'b0, a3);
        stop_c();
        chk("ai_acks",    {28'h0, a0, a1, a2, a3}, 32'h0);
        chk("ai_regs",    regs_o, 32'h1100AA22);
        chk("ai_stb_cnt", 32'(idx_log.size() - base), 32'd2);
        chk("ai_idx0",    32'(idx_log[base]), 32'd3);
        chk("ai_idx1",    32'(idx_log[base + 1]), 32'd0);

        // Prepare reg2 = C3
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        write_byte(8'h02, 1'b0, a1);
        write_byte(8'hC3, 1'b0, a2);
        stop_c();
        chk("prep_regs", regs_o, 32'h11C3AA22);

        // Read reg2, reg3 after repeated START
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        write_byte(8'h02, 1'b0, a1);
        rstart_c();
        write_byte(8'hF1, 1'b0, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        chk("rd_acks",  {29'h0, a0, a1, a2}, 32'h0);
        chk("rd_byte0", 32'(d0), 32'h000000C3);
        chk("rd_byte1", 32'(d1), 32'h00000011);
        tick(12);
        chk("rd_release", 32'(sda_oe), 32'h0);
        stop_c();
        chk("rd_busy_end", 32'(busy), 32'h0);

        // Reset while driving a 0 bit (pointer wrapped to 0, reg0 = 22, MSB 0)
        start_c();
        write_byte(8'hF1, 1'b0, a0);
        chk("mr_ack", 32'(a0), 32'h0);
        tick(12);
        chk("mr_driving", 32'(sda_oe), 32'h1);
        areset = 1'b1;
        tick(1);
        chk("mr_sda_oe", 32'(sda_oe), 32'h0);
        chk("mr_busy",   32'(busy),   32'h0);
        chk("mr_regs",   regs_o,      32'h0);
        areset = 1'b0;
        stop_c();
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        chk("mr_after_ack", 32'(a0), 32'h0);
        stop_c();

        // One-cycle sda glitch while scl is high must not look like START
        base = idx_log.size();
        start_c();
        write_byte(8'hF0, 1'b0, a0);
        write_byte(8'h81, 1'b1, a1);
        chk("gl_ack_ptr", 32'(a1), 32'h0);
        chk("gl_busy",    32'(busy), 32'h1);
        write_byte(8'h77, 1'b0, a2);
        chk("gl_ack_data", 32'(a2), 32'h0);
        stop_c();
        chk("gl_regs", regs_o, 32'h00007700);
        chk("gl_idx",  32'(idx_log.size() - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
